vrf_wb_arbiter: RTL and testbench

VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

---
 rtl/vrf_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_vrf_wb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vrf_wb_arbiter
// Brief    : Two-requester arbiter feeding one vector register-file writeback
//            port through a single output stage with alignment checking.
//            Define VRF_WB_RR_EN for round-robin ties (default: A wins ties).
// Revision : 1.0
// ============================================================================
module vrf_wb_arbiter #(
    parameter int SEL_W   = 5,
    parameter int VLMUL_W = 3,
    parameter int DATA_W  = 256
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               a_valid,
    output logic               a_ready,
    input  logic [SEL_W-1:0]   a_sel,
    input  logic [VLMUL_W-1:0] a_vlmul,
    input  logic [DATA_W-1:0]  a_data,

    input  logic               b_valid,
    output logic               b_ready,
    input  logic [SEL_W-1:0]   b_sel,
    input  logic [VLMUL_W-1:0] b_vlmul,
    input  logic [DATA_W-1:0]  b_data,

    output logic [SEL_W-1:0]   wb_sel,
    output logic [VLMUL_W-1:0] wb_vlmul,
    output logic [DATA_W-1:0]  wb_in,
    output logic               wb_load,
    input  logic               wb_stall,

    output logic               err_misalign,
    output logic               last_grant
);

    // Register group base must be aligned to the group size 1/2/4/8;
    // vlmul codes 4..7 are reserved and never legal.
    function automatic logic f_legal(input logic [SEL_W-1:0]   sel,
                                     input logic [VLMUL_W-1:0] vlmul);
        logic [SEL_W-1:0] mask;
        logic             ok;
        mask = '0;
        ok   = 1'b1;
        case (vlmul)
            3'd0:    mask = 5'b00000;
            3'd1:    mask = 5'b00001;
            3'd2:    mask = 5'b00011;
            3'd3:    mask = 5'b00111;
            default: ok   = 1'b0;
        endcase
        return ok && ((sel & mask) == '0);
    endfunction

    logic               r_out_valid;
    logic [SEL_W-1:0]   r_out_sel;
    logic [VLMUL_W-1:0] r_out_vlmul;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_err;
    logic               r_last_grant;

    logic               w_can_accept;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_xfer_a;
    logic               w_xfer_b;
    logic               w_xfer;
    logic [SEL_W-1:0]   w_win_sel;
    logic [VLMUL_W-1:0] w_win_vlmul;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_win_legal;
    logic               w_load_new;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (a_valid && b_valid) begin
`ifdef VRF_WB_RR_EN
            // The requester that did not win last time takes the tie.
            if (r_last_grant) w_grant_a = 1'b1;
            else              w_grant_b = 1'b1;
`else
            w_grant_a = 1'b1;
`endif
        end else if (a_valid) begin
            w_grant_a = 1'b1;
        end else if (b_valid) begin
            w_grant_b = 1'b1;
        end
    end

    assign w_can_accept = ~r_out_valid | ~wb_stall;

    // Ready is gated by reset so it drops the instant reset asserts.
    assign a_ready = reset & w_can_accept & w_grant_a;
    assign b_ready = reset & w_can_accept & w_grant_b;

    assign w_xfer_a = a_valid & a_ready;
    assign w_xfer_b = b_valid & b_ready;
    assign w_xfer   = w_xfer_a | w_xfer_b;

    assign w_win_sel   = w_xfer_b ? b_sel   : a_sel;
    assign w_win_vlmul = w_xfer_b ? b_vlmul : a_vlmul;
    assign w_win_data  = w_xfer_b ? b_data  : a_data;
    assign w_win_legal = f_legal(w_win_sel, w_win_vlmul);
    assign w_load_new  = w_xfer & w_win_legal;

    assign wb_load      = r_out_valid & ~wb_stall;
    assign wb_sel       = r_out_sel;
    assign wb_vlmul     = r_out_vlmul;
    assign wb_in        = r_out_data;
    assign err_misalign = r_err;
    assign last_grant   = r_last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_sel    <= '0;
            r_out_vlmul  <= '0;
            r_out_data   <= '0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            // A new entry may overwrite the one being drained this cycle.
            if (w_load_new) begin
                r_out_valid <= 1'b1;
                r_out_sel   <= w_win_sel;
                r_out_vlmul <= w_win_vlmul;
                r_out_data  <= w_win_data;
            end else if (wb_load) begin
                r_out_valid <= 1'b0;
            end
            r_err <= w_xfer & ~w_win_legal;
            if (w_xfer) begin
                r_last_grant <= w_xfer_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vrf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vrf_wb_arbiter
// Brief    : Self-checking bench for vrf_wb_arbiter against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_vrf_wb_arbiter;

`ifdef VRF_WB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [4:0]   a_sel, b_sel, wb_sel;
    logic [2:0]   a_vlmul, b_vlmul, wb_vlmul;
    logic [255:0] a_data, b_data, wb_in;
    logic         wb_load, wb_stall, err_misalign, last_grant;

    always #5 clk = ~clk;

    vrf_wb_arbiter u_dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_sel        (a_sel),
        .a_vlmul      (a_vlmul),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_sel        (b_sel),
        .b_vlmul      (b_vlmul),
        .b_data       (b_data),
        .wb_sel       (wb_sel),
        .wb_vlmul     (wb_vlmul),
        .wb_in        (wb_in),
        .wb_load      (wb_load),
        .wb_stall     (wb_stall),
        .err_misalign (err_misalign),
        .last_grant   (last_grant)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_loads = 0;

    // Reference model state: what the writeback stage should hold.
    bit           m_ov;
    logic [4:0]   m_sel;
    logic [2:0]   m_vl;
    logic [255:0] m_data;
    bit           m_lg;
    bit           m_err;
    bit           e_ar, e_br, e_load;
    bit           o_ar, o_br, o_load;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int sel, input int vl);
        if (vl > 3) return 1'b0;
        return (sel % (1 << vl)) == 0;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        bit can, ga, gb, xfer, win_b;
        logic [4:0]   s;
        logic [2:0]   l;
        logic [255:0] d;
        #1;
        can = !m_ov || !wb_stall;
        ga = 1'b0;
        gb = 1'b0;
        if (a_valid && b_valid) begin
            if (c_RR && !m_lg) gb = 1'b1;
            else               ga = 1'b1;
        end else if (a_valid) ga = 1'b1;
        else if (b_valid)     gb = 1'b1;
        e_ar   = can && ga;
        e_br   = can && gb;
        e_load = m_ov && !wb_stall;
        check_eq("a_ready", a_ready, e_ar);
        check_eq("b_ready", b_ready, e_br);
        check_eq("wb_load", wb_load, e_load);
        check_eq("err_misalign", err_misalign, m_err);
        check_eq("last_grant", last_grant, m_lg);
        if (m_ov) begin
            check_eq("wb_sel", wb_sel, m_sel);
            check_eq("wb_vlmul", wb_vlmul, m_vl);
            check_eq("wb_in", wb_in, m_data);
        end
        o_ar   = a_ready;
        o_br   = b_ready;
        o_load = wb_load;
        if (wb_load) n_loads++;
        @(posedge clk);
        xfer  = (e_ar && a_valid) || (e_br && b_valid);
        win_b = e_br && b_valid;
        s = win_b ? b_sel   : a_sel;
        l = win_b ? b_vlmul : a_vlmul;
        d = win_b ? b_data  : a_data;
        m_err = 1'b0;
        if (xfer) begin
            m_lg = win_b;
            if (legal(int'(s), int'(l))) begin
                m_ov = 1'b1; m_sel = s; m_vl = l; m_data = d;
            end else begin
                m_err = 1'b1;
                if (e_load) m_ov = 1'b0;
            end
        end else if (e_load) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the forced values at once, then releases.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst wb_load", wb_load, 1'b0);
        check_eq("rst a_ready", a_ready, 1'b0);
        check_eq("rst b_ready", b_ready, 1'b0);
        check_eq("rst err", err_misalign, 1'b0);
        check_eq("rst last_grant", last_grant, 1'b1);
        check_eq("rst wb_sel", wb_sel, 5'd0);
        check_eq("rst wb_vlmul", wb_vlmul, 3'd0);
        check_eq("rst wb_in", wb_in, 256'd0);
        m_ov = 1'b0; m_sel = '0; m_vl = '0; m_data = '0; m_lg = 1'b1; m_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_req(output logic v, output logic [4:0] s, output logic [2:0] l,
                            output logic [255:0] d);
        v = ($urandom_range(0, 99) < 60);
        l = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        s = 5'($urandom_range(0, 31));
        if (l < 3'd4 && $urandom_range(0, 1) == 1) s = s & ~5'((1 << l) - 1);
        d = rand256();
    endtask

    initial begin
        logic [255:0] d1, d2, d3;
        int           got_g, exp_g;

        reset = 1'b0;
        a_valid = 1'b0; a_sel = '0; a_vlmul = '0; a_data = '0;
        b_valid = 1'b0; b_sel = '0; b_vlmul = '0; b_data = '0;
        wb_stall = 1'b0;
        m_ov = 1'b0; m_sel = '0; m_vl = '0; m_data = '0; m_lg = 1'b1; m_err = 1'b0;

        @(negedge clk);
        do_reset();

        // Single aligned request from A, written one cycle later.
        d1 = rand256();
        a_valid = 1'b1; a_sel = 5'd8; a_vlmul = 3'd2; a_data = d1;
        step();
        check_eq("first a_ready", o_ar, 1'b1);
        a_valid = 1'b0;
        #1;
        check_eq("first wb_load", wb_load, 1'b1);
        check_eq("first wb_sel", wb_sel, 5'd8);
        check_eq("first wb_vlmul", wb_vlmul, 3'd2);
        check_eq("first wb_in", wb_in, d1);
        step();

        // Both requesters held valid: tie-break sequence from a fresh reset.
        do_reset();
        a_valid = 1'b1; a_sel = 5'd0; a_vlmul = 3'd0; a_data = rand256();
        b_valid = 1'b1; b_sel = 5'd2; b_vlmul = 3'd1; b_data = rand256();
        for (int i = 0; i < 4; i++) begin
            step();
            got_g = o_ar ? 0 : (o_br ? 1 : 2);
            exp_g = c_RR ? (i % 2) : 0;
            check_eq("tie grant", got_g, exp_g);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        step();

        // Stage full and stalled for three cycles while A waits.
        d2 = rand256();
        d3 = rand256();
        a_valid = 1'b1; a_sel = 5'd4; a_vlmul = 3'd2; a_data = d2;
        step();
        a_sel = 5'd16; a_vlmul = 3'd3; a_data = d3;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall a_ready", o_ar, 1'b0);
            check_eq("stall wb_load", o_load, 1'b0);
            check_eq("stall wb_in", wb_in, d2);
        end
        wb_stall = 1'b0;
        step();
        check_eq("unstall a_ready", o_ar, 1'b1);
        check_eq("unstall wb_load", o_load, 1'b1);
        a_valid = 1'b0;
        step();
        step();

        // Misaligned and reserved-vlmul requests from B.
        b_valid = 1'b1; b_sel = 5'd6; b_vlmul = 3'd2; b_data = rand256();
        step();
        check_eq("misalign b_ready", o_br, 1'b1);
        b_valid = 1'b0;
        #1;
        check_eq("misalign err", err_misalign, 1'b1);
        check_eq("misalign wb_load", wb_load, 1'b0);
        step();
        b_valid = 1'b1; b_sel = 5'($urandom_range(0, 31)); b_vlmul = 3'd5;
        step();
        check_eq("reserved b_ready", o_br, 1'b1);
        b_valid = 1'b0;
        #1;
        check_eq("reserved err", err_misalign, 1'b1);
        check_eq("reserved wb_load", wb_load, 1'b0);
        step();
        step();

        // Reset while an entry is pending: the entry must never be written.
        a_valid = 1'b1; a_sel = 5'd3; a_vlmul = 3'd0; a_data = rand256();
        step();
        a_valid = 1'b1;
        #1;
        check_eq("pre-reset wb_load", wb_load, 1'b1);
        do_reset();
        a_valid = 1'b0;
        step();
        check_eq("post-reset wb_load", o_load, 1'b0);
        step();

        // Back-to-back stream from A: one write per cycle, in order.
        n_loads = 0;
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_sel = 5'(i * 2); a_vlmul = 3'd1; a_data = 256'(i + 100);
            step();
        end
        a_valid = 1'b0;
        step();
        step();
        check_eq("stream loads", n_loads, 8);

        // Randomized traffic; a valid request that was not accepted is held stable.
        o_ar = 1'b1;
        o_br = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (!(a_valid && !o_ar)) rand_req(a_valid, a_sel, a_vlmul, a_data);
            if (!(b_valid && !o_br)) rand_req(b_valid, b_sel, b_vlmul, b_data);
            wb_stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                o_ar = 1'b1;
                o_br = 1'b1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
